// File: rtl/spi_pwm_pkg.sv
// Shared constants and types for the SPI-configured PWM bank.
package spi_pwm_pkg;

  localparam logic [6:0] ADDR_TOP  = 7'h7E;
  localparam logic [6:0] ADDR_CTRL = 7'h7F;

  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_IMM = 1;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RD_DATA,
    WR_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave front end: pin synchronisers, edge detection, bit/byte
// counting, receive shift register and word-wide transmit shift register.
module spi_slave_sync #(
  parameter int unsigned TX_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sclk,
  input  logic            cs_n,
  input  logic            mosi,
  input  logic            tx_load,
  input  logic [TX_W-1:0] tx_data,
  output logic            frame_active_c,
  output logic            byte_valid,
  output logic            byte_first,
  output logic [7:0]      byte_data,
  output logic            miso
);

  logic [2:0]      sclk_q;
  logic [1:0]      cs_q;
  logic [1:0]      mosi_q;
  logic            armed_q;
  logic [2:0]      bit_cnt;
  logic [7:0]      byte_cnt;
  logic [7:0]      rx_sr;
  logic [TX_W-1:0] tx_sr;
  logic [TX_W-1:0] tx_buf;
  logic            tx_pend;

  logic sclk_rise_c;
  logic sclk_fall_c;
  logic cs_s_c;
  logic mosi_s_c;

  assign sclk_rise_c    = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall_c    = ~sclk_q[1] & sclk_q[2];
  assign cs_s_c         = cs_q[1];
  assign mosi_s_c       = mosi_q[1];
  // A frame only counts once cs_n has been seen high since the last reset.
  assign frame_active_c = armed_q & ~cs_s_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q     <= '0;
      cs_q       <= '1;
      mosi_q     <= '0;
      armed_q    <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      tx_buf     <= '0;
      tx_pend    <= 1'b0;
      miso       <= 1'b0;
      byte_valid <= 1'b0;
      byte_first <= 1'b0;
      byte_data  <= '0;
    end else begin
      sclk_q     <= {sclk_q[1:0], sclk};
      cs_q       <= {cs_q[0], cs_n};
      mosi_q     <= {mosi_q[0], mosi};
      byte_valid <= 1'b0;
      if (cs_s_c) begin
        armed_q <= 1'b1;
      end
      if (!frame_active_c) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        rx_sr    <= '0;
        tx_sr    <= '0;
        tx_pend  <= 1'b0;
        miso     <= 1'b0;
      end else begin
        if (tx_load) begin
          tx_buf <= tx_data;
        end
        if (sclk_rise_c) begin
          rx_sr   <= {rx_sr[6:0], mosi_s_c};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_valid <= 1'b1;
            byte_first <= (byte_cnt == 8'd0);
            byte_data  <= {rx_sr[6:0], mosi_s_c};
            if (byte_cnt != 8'hFF) begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
        end
        // A pending word replaces the shift register at the next falling edge.
        if (sclk_fall_c) begin
          tx_pend <= tx_load;
          if (tx_pend) begin
            miso  <= tx_buf[TX_W-1];
            tx_sr <= {tx_buf[TX_W-2:0], 1'b0};
          end else begin
            miso  <= tx_sr[TX_W-1];
            tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
          end
        end else if (tx_load) begin
          tx_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_pwm_bank.sv
// N-channel PWM bank with double-buffered duties, programmable period and
// an SPI mode-0 register port supporting auto-incrementing bursts.
module spi_pwm_bank
  import spi_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = 7,
  parameter int unsigned PWM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int unsigned DATA_BYTES = (PWM_W + 7) / 8;
  localparam int unsigned TX_W       = DATA_BYTES * 8;
  localparam int unsigned WB_W       = 1;

  spi_state_e      state_q, state_d;
  logic [6:0]      addr_q, addr_d;
  logic [WB_W-1:0] wb_q, wb_d;
  logic [TX_W-1:0] word_q, word_d;

  logic            frame_active_c;
  logic            byte_valid;
  logic            byte_first;
  logic [7:0]      byte_data;
  logic            tx_load_c;
  logic [TX_W-1:0] tx_data_c;
  logic            wr_en_c;
  logic [TX_W-1:0] asm_word_c;
  logic [PWM_W-1:0] wr_data_c;
  logic [6:0]      rd_addr_c;
  logic [PWM_W-1:0] rd_data_c;

  logic [PWM_W-1:0] shadow_q [NUM_CH];
  logic [PWM_W-1:0] active_q [NUM_CH];
  logic [PWM_W-1:0] top_q;
  logic [PWM_W-1:0] cnt_q;
  logic             en_q;
  logic             imm_q;
  logic             wrap_c;

  spi_slave_sync #(
    .TX_W (TX_W)
  ) u_spi (
    .clk            (clk),
    .reset          (reset),
    .sclk           (sclk),
    .cs_n           (cs_n),
    .mosi           (mosi),
    .tx_load        (tx_load_c),
    .tx_data        (tx_data_c),
    .frame_active_c (frame_active_c),
    .byte_valid     (byte_valid),
    .byte_first     (byte_first),
    .byte_data      (byte_data),
    .miso           (miso)
  );

  assign asm_word_c = TX_W'({word_q, byte_data});
  assign wr_data_c  = PWM_W'(asm_word_c);
  // The next read word is the start address after the command, else addr+1.
  assign rd_addr_c  = (state_q == CMD) ? byte_data[6:0] : addr_q + 7'd1;

  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_addr_c == 7'(i)) begin
        rd_data_c = shadow_q[i];
      end
    end
    if (rd_addr_c == ADDR_TOP) begin
      rd_data_c = top_q;
    end
    if (rd_addr_c == ADDR_CTRL) begin
      rd_data_c           = '0;
      rd_data_c[CTRL_EN]  = en_q;
      rd_data_c[CTRL_IMM] = imm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wb_q    <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wb_q    <= wb_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wb_d      = wb_q;
    word_d    = word_q;
    wr_en_c   = 1'b0;
    tx_load_c = 1'b0;
    tx_data_c = TX_W'(rd_data_c);
    case (state_q)
      IDLE: begin
        if (frame_active_c) begin
          state_d = CMD;
          wb_d    = '0;
          word_d  = '0;
        end
      end
      CMD: begin
        if (!frame_active_c) begin
          state_d = IDLE;
        end else if (byte_valid && byte_first) begin
          addr_d = byte_data[6:0];
          wb_d   = '0;
          if (byte_data[7]) begin
            state_d = WR_DATA;
          end else begin
            state_d   = RD_DATA;
            tx_load_c = 1'b1;
          end
        end
      end
      RD_DATA, WR_DATA: begin
        if (!frame_active_c) begin
          state_d = IDLE;
        end else if (byte_valid) begin
          word_d = asm_word_c;
          if (wb_q == WB_W'(DATA_BYTES - 1)) begin
            wb_d      = '0;
            addr_d    = addr_q + 7'd1;
            tx_load_c = 1'b1;
            if (state_q == WR_DATA) begin
              wr_en_c   = 1'b1;
              tx_data_c = asm_word_c;
            end
          end else begin
            wb_d = wb_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file writes; the duty latch reads the pre-write shadow value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= '0;
      end
      top_q <= {{(PWM_W-1){1'b1}}, 1'b0};
      en_q  <= 1'b1;
      imm_q <= 1'b0;
    end else if (wr_en_c) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr_q == 7'(i)) begin
          shadow_q[i] <= wr_data_c;
        end
      end
      if (addr_q == ADDR_TOP) begin
        top_q <= wr_data_c;
      end
      if (addr_q == ADDR_CTRL) begin
        en_q  <= wr_data_c[CTRL_EN];
        imm_q <= wr_data_c[CTRL_IMM];
      end
    end
  end

  // A count above a freshly lowered TOP also wraps immediately.
  assign wrap_c = (cnt_q >= top_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      pwm_out <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        active_q[i] <= '0;
      end
    end else begin
      cnt_q <= wrap_c ? '0 : cnt_q + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wrap_c || imm_q) begin
          active_q[i] <= shadow_q[i];
        end
        pwm_out[i] <= en_q && (cnt_q < active_q[i]);
      end
    end
  end

endmodule

// File: tb/tb_spi_pwm_bank.sv
// Directed bench for spi_pwm_bank with a cycle-level behavioural PWM model.
module tb_spi_pwm_bank;

  localparam int unsigned NUM_CH = 7;
  localparam int unsigned PWM_W  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [NUM_CH-1:0] pwm_out;

  always #5 clk = ~clk;

  spi_pwm_bank #(
    .NUM_CH (NUM_CH),
    .PWM_W  (PWM_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .pwm_out (pwm_out)
  );

  int n_err = 0;
  int n_chk = 0;
  bit chk_on = 1'b0;
  int cyc = 0;

  // Model: period TOP+1, duties swap in at wrap (or every clk with IMM),
  // SPI writes take effect 4 clk after the sclk rise ending a word.
  typedef struct {
    int due;
    int addr;
    int data;
  } wr_t;
  wr_t pend[$];

  int m_cnt;
  int m_top;
  int m_shadow [NUM_CH];
  int m_active [NUM_CH];
  bit m_en;
  bit m_imm;
  logic [NUM_CH-1:0] m_pwm;

  always @(posedge clk) begin : model
    int sh [NUM_CH];
    int tp;
    bit en;
    bit imm;
    logic [NUM_CH-1:0] p;
    cyc <= cyc + 1;
    if (reset) begin
      m_cnt <= 0;
      m_top <= 254;
      m_en  <= 1'b1;
      m_imm <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] <= 0;
        m_active[i] <= 0;
      end
      m_pwm <= '0;
      pend.delete();
    end else begin
      for (int i = 0; i < NUM_CH; i++) p[i] = m_en && (m_cnt < m_active[i]);
      m_pwm <= p;
      if (m_cnt >= m_top || m_imm)
        for (int i = 0; i < NUM_CH; i++) m_active[i] <= m_shadow[i];
      m_cnt <= (m_cnt >= m_top) ? 0 : m_cnt + 1;
      sh  = m_shadow;
      tp  = m_top;
      en  = m_en;
      imm = m_imm;
      while (pend.size() > 0 && pend[0].due == cyc + 1) begin
        if (pend[0].addr < NUM_CH) sh[pend[0].addr] = pend[0].data & 255;
        else if (pend[0].addr == 126) tp = pend[0].data & 255;
        else if (pend[0].addr == 127) begin
          en  = pend[0].data[0];
          imm = pend[0].data[1];
        end
        void'(pend.pop_front());
      end
      m_shadow <= sh;
      m_top    <= tp;
      m_en     <= en;
      m_imm    <= imm;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_chk++;
      if (pwm_out !== m_pwm) begin
        n_err++;
        $display("FAIL pwm_cycle t=%0t: got %b expected %b", $time, pwm_out, m_pwm);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                          input bit push, input int paddr, input int hi, input int lo);
    wr_t w;
    rx = '0;
    for (int b = hi; b >= lo; b--) begin
      mosi = tx[b];
      tick(4);
      rx[b] = miso;
      sclk = 1'b1;
      if (push && b == lo) begin
        w.due  = cyc + 4;
        w.addr = paddr;
        w.data = int'(tx);
        pend.push_back(w);
      end
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] cmd, input int n, input logic [7:0] wd [8],
                       output logic [7:0] rd [8]);
    logic [7:0] d;
    int a;
    a = int'(cmd[6:0]);
    cs_n = 1'b0;
    tick(4);
    spi_byte(cmd, d, 1'b0, 0, 7, 0);
    for (int k = 0; k < n; k++) begin
      spi_byte(wd[k], rd[k], cmd[7], a, 7, 0);
      a = (a + 1) % 128;
    end
    tick(4);
    cs_n = 1'b1;
    tick(8);
  endtask

  task automatic wr1(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] wd [8];
    logic [7:0] rd [8];
    wd = '{default: 8'h00};
    wd[0] = d;
    frame({1'b1, a}, 1, wd, rd);
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a, input int n, input logic [7:0] exp [8]);
    logic [7:0] wd [8];
    logic [7:0] rd [8];
    wd = '{default: 8'h00};
    frame({1'b0, a}, n, wd, rd);
    for (int k = 0; k < n; k++) check($sformatf("%s_w%0d", name, k), int'(rd[k]), int'(exp[k]));
  endtask

  task automatic wait_cnt(input int v);
    bit hit = 1'b0;
    for (int t = 0; t < 700 && !hit; t++) begin
      if (m_cnt == v) hit = 1'b1;
      else tick(1);
    end
    if (!hit) check("wait_cnt_timeout", 0, 1);
  endtask

  task automatic count_high(input int len, output int h [NUM_CH]);
    for (int i = 0; i < NUM_CH; i++) h[i] = 0;
    repeat (len) begin
      tick(1);
      for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) h[i]++;
    end
  endtask

  task automatic meas_period(input int ch, input int exp, input string name);
    int n;
    bit prev;
    bit found;
    found = 1'b0;
    prev  = pwm_out[ch];
    for (int t = 0; t < 1000 && !found; t++) begin
      tick(1);
      found = !prev && pwm_out[ch];
      prev  = pwm_out[ch];
    end
    if (!found) begin
      check({name, "_timeout"}, -1, exp);
    end else begin
      n = 0;
      found = 1'b0;
      for (int t = 0; t < 1000 && !found; t++) begin
        tick(1);
        n++;
        found = !prev && pwm_out[ch];
        prev  = pwm_out[ch];
      end
      check(name, n, exp);
    end
  endtask

  initial begin
    logic [7:0] wd [8];
    logic [7:0] rd [8];
    logic [7:0] ex [8];
    logic [7:0] d;
    int h [NUM_CH];

    reset = 1'b1;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    tick(3);
    reset  = 1'b0;
    chk_on = 1'b1;
    check("reset_miso", int'(miso), 0);
    check("reset_pwm", int'(pwm_out), 0);

    tick(600);
    check("idle_pwm", int'(pwm_out), 0);
    ex = '{default: 8'h00};
    ex[0] = 8'h01;
    rd_chk("rd_ctrl", 7'h7F, 1, ex);
    ex[0] = 8'hFE;
    rd_chk("rd_top", 7'h7E, 1, ex);

    // Burst write ch0..2 and watch the echo of the previous word.
    wd = '{default: 8'h00};
    wd[0] = 8'h40; wd[1] = 8'h80; wd[2] = 8'hFF;
    frame(8'h80, 3, wd, rd);
    check("echo_w0", int'(rd[0]), 0);
    check("echo_w1", int'(rd[1]), 8'h40);
    check("echo_w2", int'(rd[2]), 8'h80);
    tick(600);
    count_high(255, h);
    check("high_ch0", h[0], 64);
    check("high_ch1", h[1], 128);
    check("high_ch2", h[2], 255);
    check("high_ch3", h[3], 0);
    meas_period(0, 255, "period_top254");

    ex = '{default: 8'h00};
    ex[0] = 8'h40; ex[1] = 8'h80; ex[2] = 8'hFF;
    rd_chk("rd_burst0", 7'h00, 3, ex);
    ex = '{default: 8'h00};
    ex[1] = 8'hFE; ex[2] = 8'h01; ex[3] = 8'h40;
    rd_chk("rd_wrap7d", 7'h7D, 4, ex);
    ex = '{default: 8'h00};
    rd_chk("rd_unmapped", 7'h07, 2, ex);

    // Partial word: 8 command bits + 4 data bits, then cs_n high.
    cs_n = 1'b0;
    tick(4);
    spi_byte(8'h81, d, 1'b0, 0, 7, 0);
    spi_byte(8'h11, d, 1'b0, 0, 7, 4);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    ex = '{default: 8'h00};
    ex[0] = 8'h80;
    rd_chk("partial_kept", 7'h01, 1, ex);

    // Shadow write mid-period takes effect at the next wrap only.
    wait_cnt(100);
    wr1(7'h00, 8'h10);
    wait_cnt(10);
    check("new_duty_on", int'(pwm_out[0]), 1);
    wait_cnt(40);
    check("new_duty_off", int'(pwm_out[0]), 0);
    tick(300);
    count_high(255, h);
    check("high_ch0_16", h[0], 16);

    // Immediate mode: duty applies within a couple of clk.
    wr1(7'h7F, 8'h03);
    wait_cnt(60);
    wr1(7'h00, 8'hF0);
    check("imm_applied", int'(pwm_out[0]), 1);
    wr1(7'h7F, 8'h01);

    // Lower TOP below the running count.
    wr1(7'h00, 8'h05);
    wait_cnt(70);
    wr1(7'h7E, 8'h09);
    tick(50);
    count_high(10, h);
    check("top9_ch0", h[0], 5);
    check("top9_ch1", h[1], 10);
    meas_period(0, 10, "period_top9");

    // Reset in the middle of a write frame; the rest of the frame is ignored.
    cs_n = 1'b0;
    tick(4);
    spi_byte(8'h80, d, 1'b0, 0, 7, 5);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    spi_byte(8'h80, d, 1'b0, 0, 4, 0);
    spi_byte(8'h77, d, 1'b0, 0, 7, 0);
    check("rst_frame_miso", int'(miso), 0);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    check("rst_pwm", int'(pwm_out), 0);
    ex = '{default: 8'h00};
    ex[0] = 8'hFE; ex[1] = 8'h01; ex[2] = 8'h00; ex[3] = 8'h00;
    rd_chk("rst_regs", 7'h7E, 4, ex);
    tick(300);
    check("rst_pwm_late", int'(pwm_out), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
